// File: rtl/stupidrv_pkg.sv
// Shared constants for the stupidrv console output peripheral.
// Holds the console address map, STATUS bit layout and the byte-merge helper.
package stupidrv_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned STRB_W = BUS_W / 8;

    localparam logic [31:0] CONSOLE_BASE_ADDR  = 32'h0200_0000;
    localparam logic [31:0] CONSOLE_DATA_OFS   = 32'h0000_0000;
    localparam logic [31:0] CONSOLE_STATUS_OFS = 32'h0000_0004;

    // STATUS register layout: [15:0] count, then flags; upper bits read 0.
    localparam int unsigned ST_COUNT_W = 16;
    localparam int unsigned ST_FULL    = 16;
    localparam int unsigned ST_EMPTY   = 17;
    localparam int unsigned ST_OVF     = 18;

    // Keep only the bytes enabled by strb; disabled lanes become zero.
    function automatic logic [BUS_W-1:0] merge_bytes(input logic [STRB_W-1:0] strb,
                                                     input logic [BUS_W-1:0]  data);
        logic [BUS_W-1:0] res;
        res = '0;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stupidrv_sync_fifo.sv
// Synchronous FIFO without fall-through.
// Ports: clk, rst_n (sync, active-low), push/din, pop, dout (head word, 0 when empty),
//        count (DEPTH_LOG2+1 bits), full, empty.
// A push while full is accepted only when a pop happens in the same cycle.
module stupidrv_sync_fifo #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the head being popped this cycle.
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    // Gate with empty so the head never shows stale or uninitialised storage.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are only observable through dout when non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/stupidrv_console_out.sv
// Memory-mapped console output peripheral on the stupidrv dmem bus.
// Ports: clock, reset (sync, active-low); dmem_valid/addr/wstrb/wdata in, dmem_rdata out
//        (registered, one cycle after a read); sel (combinational address hit);
//        out_valid/out_ready/out_data stream from the FIFO head; overflow (sticky drop flag).
// DATA at BASE_ADDR pushes byte-merged store data; STATUS at BASE_ADDR+4 reports
// count/full/empty/overflow and clears overflow on a write of bit 18.
module stupidrv_console_out
    import stupidrv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = CONSOLE_BASE_ADDR,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dmem_valid,
    input  logic [31:0]       dmem_addr,
    input  logic [3:0]        dmem_wstrb,
    input  logic [31:0]       dmem_wdata,
    output logic [31:0]       dmem_rdata,
    output logic              sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              overflow
);

    localparam int unsigned CNT_W       = DEPTH_LOG2 + 1;
    localparam logic [29:0] DATA_WORD   = BASE_ADDR[31:2] + CONSOLE_DATA_OFS[31:2];
    localparam logic [29:0] STATUS_WORD = BASE_ADDR[31:2] + CONSOLE_STATUS_OFS[31:2];

    logic             is_data;
    logic             is_status;
    logic             is_write;
    logic             push;
    logic             pop;
    logic             drop;
    logic             ovf_clear;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      status_word;
    logic [31:0]      rdata_next;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^dmem_addr[1:0];

    // Address decode; byte offset within the word is ignored.
    assign is_data   = (dmem_addr[31:2] == DATA_WORD);
    assign is_status = (dmem_addr[31:2] == STATUS_WORD);
    assign sel       = dmem_valid && (is_data || is_status);
    assign is_write  = |dmem_wstrb;

    assign push      = sel && is_data && is_write;
    assign pop       = out_valid && out_ready;
    assign drop      = push && fifo_full && !pop;
    assign ovf_clear = sel && is_status && dmem_wstrb[ST_OVF / 8] && dmem_wdata[ST_OVF];
    assign out_valid = !fifo_empty;

    stupidrv_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (32)
    ) u_fifo (
        .clk   (clock),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .din   (merge_bytes(dmem_wstrb, dmem_wdata)),
        .dout  (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // STATUS word and read-data selection from pre-update state.
    always_comb begin
        status_word                   = '0;
        status_word[ST_COUNT_W-1:0]   = ST_COUNT_W'(fifo_count);
        status_word[ST_FULL]          = fifo_full;
        status_word[ST_EMPTY]         = fifo_empty;
        status_word[ST_OVF]           = overflow;
        rdata_next                    = '0;
        if (sel && !is_write && is_status) begin
            rdata_next = status_word;
        end
    end

    // Sticky overflow (set beats clear) and the registered read port.
    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow   <= 1'b0;
            dmem_rdata <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
            dmem_rdata <= rdata_next;
        end
    end

endmodule
